muxsplit_bbm_seq: RTL
=====================

# muxsplit_bbm_seq

Break-before-make sequencer for the analog mux/split switch bank: four quadrants (se, sw, ne, nw) with six switches each (aa_sl, aa_s0, bb_s0, bb_sl, bb_sr, aa_sr). It sits between the system configuration registers and the switch control outputs. On each new requested switch pattern it opens every switch that must open, waits a programmable dead time, and only then closes the newly requested switches. This guarantees that no two analog paths are ever momentarily shorted during reconfiguration.

## Interface
Parameters:
- N, 24, number of switch controls (4 quadrants × 6); bit index = quadrant*6 + switch, quadrant order se=0, sw=1, ne=2, nw=3; switch order aa_sl=0, aa_s0=1, bb_s0=2, bb_sl=3, bb_sr=4, aa_sr=5.
- DEAD_W, 8, width of the dead-time counter.

Ports:
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  new switch pattern offered.
- req_sw  in  N  requested pattern; 1 = switch closed.
- req_ready  out  1  sequencer can accept a request.
- dead_cycles  in  DEAD_W  dead time; sampled when a request is accepted.
- force_open  in  1  synchronous emergency open of all switches.
- sw_out  out  N  registered switch drive; 1 = closed.
- busy  out  1  break/dead phase in progress.
- done  out  1  one-cycle pulse when the target pattern is applied.

## Operation
- State: target register (N), counter (DEAD_W), FSM {IDLE, DEAD}.
- req_ready = (state == IDLE) & ~force_open. busy = (state == DEAD).
- Accept = req_valid & req_ready at a rising edge. The target is latched and close = req_sw & ~sw_out.
- IDLE, accept, close == 0 (the request only opens switches or changes nothing): sw_out <= req_sw, done <= 1, stay in IDLE.
- IDLE, accept, close != 0: sw_out <= sw_out & req_sw (break: open the switches being removed, keep the common ones closed), cnt <= dead_cycles, go to DEAD.
- DEAD, cnt != 0: cnt <= cnt - 1, sw_out held.
- DEAD, cnt == 0: sw_out <= target (make), done <= 1, go to IDLE.
- req_valid while not ready is ignored and not queued. The requester must hold req_valid until it sees req_ready.
- A change to dead_cycles during DEAD has no effect.
- force_open high at an edge: sw_out <= 0, state <= IDLE, cnt <= 0, done <= 0. It has priority over everything.
  - An aborted transition is discarded and no done pulse is issued.
  - When force_open deasserts, the block is in IDLE with all switches open, so the next request takes the close path.
- done is high for exactly one cycle per completed request. It is 0 in every other cycle.

## Timing
- Reset (async assert): sw_out = 0 (all open), state = IDLE, cnt = 0, target = 0, done = 0, busy = 0. req_ready = 1 once rst_n is high and force_open is low.
- Open-only request accepted at edge T: sw_out has its new value and done = 1 after T, and done drops after T+1. Latency is 1 cycle. A back-to-back request at T+1 is accepted.
- Closing request accepted at edge T with dead_cycles = D:
  - The break pattern is on sw_out from T through T+D+1, i.e. D+1 cycles.
  - The make (target on sw_out) and done = 1 both take effect at edge T+D+1.
  - busy is high from T to T+D+1; req_ready is low in the same window. The earliest next accept is edge T+D+2.
- D = 0 still gives a 1-cycle break before make.
- D = 2^DEAD_W - 1 gives the maximum window; there is no wrap beyond it.
- A request equal to the current sw_out takes the open-only path: 1 cycle, done pulses, sw_out unchanged.
- A switch that is closed both before and after a request is never opened during the transition.

## Test plan
- Reset: assert rst_n = 0 mid-DEAD with sw_out = 0x000003 -> sw_out = 0 immediately (asynchronously), busy = 0, done = 0; after release req_ready = 1.
- Close with dead time: sw_out = 0x000001, request 0x000006 with D = 3 -> sw_out = 0x000000 for 4 cycles, then 0x000006; done pulses once at make; req_ready is low throughout the window.
- Partial overlap: sw_out = 0x000003, request 0x000006 with D = 0 -> 1 cycle at 0x000002 (bit 1 held closed), then 0x000006.
- Open-only: sw_out = 0xFFFFFF, request 0x00F000 -> sw_out = 0x00F000 after 1 edge, done pulses, busy never asserts.
- Busy ignore: offer 0x800000 while in DEAD -> not accepted, and the ongoing target completes unchanged. Holding req_valid -> accepted on the first cycle after done, then goes through its own break phase.
- force_open during DEAD (D = 10, cycle 4) -> sw_out = 0 at the next edge, no done pulse, req_ready = 0 while force_open is held. After release, a request 0x000001 goes through a full D+1 break.

Source files
------------

// File: rtl/muxsplit_bbm_seq.sv
// Break-before-make sequencer for the analog mux/split switch bank.
// It opens the switches that are leaving, waits a dead time, then closes the new ones.
module muxsplit_bbm_seq #(
  parameter int N      = 24,
  parameter int DEAD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [N-1:0]      req_sw,
  output logic              req_ready,
  input  logic [DEAD_W-1:0] dead_cycles,
  input  logic              force_open,
  output logic [N-1:0]      sw_out,
  output logic              busy,
  output logic              done
);

  typedef enum logic {IDLE, DEAD} state_t;

  state_t              state_q, state_d;
  logic [N-1:0]        target_q, target_d;
  logic [N-1:0]        sw_d;
  logic [DEAD_W-1:0]   cnt_q, cnt_d;
  logic                done_d;
  logic                accept;
  logic [N-1:0]        close;

  assign req_ready = (state_q == IDLE) & ~force_open;
  assign busy      = (state_q == DEAD);
  assign accept    = req_valid & req_ready;
  assign close     = req_sw & ~sw_out;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    sw_d     = sw_out;
    done_d   = 1'b0;
    if (force_open) begin
      // Emergency open wins over everything; any pending target is abandoned.
      sw_d    = '0;
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            target_d = req_sw;
            if (close == '0) begin
              sw_d   = req_sw;
              done_d = 1'b1;
            end else begin
              // Break: drop removed switches, keep the common ones closed.
              sw_d    = sw_out & req_sw;
              cnt_d   = dead_cycles;
              state_d = DEAD;
            end
          end
        end
        DEAD: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            sw_d    = target_q;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      target_q <= '0;
      sw_out   <= '0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      sw_out   <= sw_d;
      done     <= done_d;
    end
  end

endmodule
